muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide unit; parametrised successor to the single-cycle integer ALU.
- Sits beside the ALU in the execute stage. The decoder steers OP instructions with funct7=0000001 here.
- Uses a valid/ready handshake on both sides, a pipeline kill input, and a configurable number of result bits per cycle.

---
 rtl/muldiv_unit_pkg.sv | 24 ++
 rtl/muldiv_step.sv | 40 ++++
 rtl/muldiv_unit.sv | 196 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 operation codes, the OP funct7 selector and the control state encoding.
package muldiv_unit_pkg;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] MULDIV_MUL    = 3'b000;
    localparam logic [2:0] MULDIV_MULH   = 3'b001;
    localparam logic [2:0] MULDIV_MULHSU = 3'b010;
    localparam logic [2:0] MULDIV_MULHU  = 3'b011;
    localparam logic [2:0] MULDIV_DIV    = 3'b100;
    localparam logic [2:0] MULDIV_DIVU   = 3'b101;
    localparam logic [2:0] MULDIV_REM    = 3'b110;
    localparam logic [2:0] MULDIV_REMU   = 3'b111;

    typedef enum logic [2:0] {
        MD_IDLE,
        MD_PREP,
        MD_CALC,
        MD_FIX,
        MD_DONE
    } md_state_e;

endpackage

// File: rtl/muldiv_step.sv
// Combinational radix-2^ITER_BITS step: shift-add multiply or restoring divide,
// built from ITER_BITS chained radix-2 stages on unsigned magnitudes.
module muldiv_step #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned ITER_BITS = 1
) (
    input  logic [XLEN-1:0] acc,
    input  logic [XLEN-1:0] operand,
    input  logic [XLEN-1:0] addend,
    input  logic            div_mode,
    output logic [XLEN-1:0] acc_next,
    output logic [XLEN-1:0] operand_next
);

    logic [XLEN:0] trial;

    always_comb begin
        acc_next     = acc;
        operand_next = operand;
        trial        = '0;
        for (int i = 0; i < int'(ITER_BITS); i++) begin
            if (div_mode) begin
                // acc is the partial remainder, operand shifts dividend out / quotient in
                trial = {acc_next, operand_next[XLEN-1]} - {1'b0, addend};
                if (!trial[XLEN]) begin
                    acc_next = trial[XLEN-1:0];
                end else begin
                    acc_next = {acc_next[XLEN-2:0], operand_next[XLEN-1]};
                end
                operand_next = {operand_next[XLEN-2:0], ~trial[XLEN]};
            end else begin
                // {acc, operand} is the product register; operand LSB is the multiplier bit
                trial = operand_next[0] ? ({1'b0, acc_next} + {1'b0, addend}) : {1'b0, acc_next};
                operand_next = {trial[0], operand_next[XLEN-1:1]};
                acc_next     = trial[XLEN:1];
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with valid/ready handshakes and kill.
// Define MULDIV_REUSE_EN to keep the last full result and answer matching requests at once.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned ITER_BITS = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] busA,
    input  logic [XLEN-1:0] busB,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] busC,
    output logic            busy
);

    localparam int unsigned NSTEPS = XLEN / ITER_BITS;
    localparam int unsigned CW     = $clog2(NSTEPS);

    md_state_e       state;
    logic [2:0]      op;
    logic [XLEN-1:0] op_a, op_b;
    logic [XLEN-1:0] acc, opnd, addend;
    logic            neg_res, neg_rem;
    logic [CW-1:0]   cnt;

    logic            is_div, sign_a_op, sign_b_op, sa, sb, b_zero, ovf;
    logic [XLEN-1:0] abs_a, abs_b;
    logic [XLEN-1:0] step_acc, step_opnd;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0] quo, rem, fix_result;
    logic            hit;
    logic [XLEN-1:0] hit_result;

    assign is_div    = op[2];
    assign sign_a_op = (op == MULDIV_MULH) || (op == MULDIV_MULHSU) ||
                       (op == MULDIV_DIV)  || (op == MULDIV_REM);
    assign sign_b_op = (op == MULDIV_MULH) || (op == MULDIV_DIV) || (op == MULDIV_REM);
    assign sa        = sign_a_op & op_a[XLEN-1];
    assign sb        = sign_b_op & op_b[XLEN-1];
    assign abs_a     = sa ? -op_a : op_a;
    assign abs_b     = sb ? -op_b : op_b;
    assign b_zero    = (op_b == '0);
    assign ovf       = is_div && !op[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);

    muldiv_step #(
        .XLEN      (XLEN),
        .ITER_BITS (ITER_BITS)
    ) u_step (
        .acc          (acc),
        .operand      (opnd),
        .addend       (addend),
        .div_mode     (is_div),
        .acc_next     (step_acc),
        .operand_next (step_opnd)
    );

    assign prod = neg_res ? -{acc, opnd} : {acc, opnd};
    assign quo  = neg_res ? -opnd : opnd;
    assign rem  = neg_rem ? -acc : acc;

    always_comb begin
        if (is_div) begin
            fix_result = op[1] ? rem : quo;
        end else begin
            fix_result = (op == MULDIV_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end
    end

`ifdef MULDIV_REUSE_EN
    logic              entry_valid;
    logic [2*XLEN-1:0] entry_data;
    logic [2*XLEN-1:0] fix_full;
    logic              tag_match;

    assign fix_full = is_div ? {quo, rem} : prod;

    // op/op_a/op_b double as the entry's tag and operands: a hit never overwrites them
    always_comb begin
        if (funct3[2]) begin
            tag_match  = op[2] && (op[0] == funct3[0]);
            hit_result = funct3[1] ? entry_data[XLEN-1:0] : entry_data[2*XLEN-1:XLEN];
        end else begin
            tag_match  = !op[2] && ((funct3 == MULDIV_MUL) || (funct3 == op));
            hit_result = (funct3 == MULDIV_MUL) ? entry_data[XLEN-1:0]
                                                : entry_data[2*XLEN-1:XLEN];
        end
        hit = entry_valid && tag_match && (busA == op_a) && (busB == op_b);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_valid <= 1'b0;
            entry_data  <= '0;
        end else if (kill) begin
            entry_valid <= 1'b0;
        end else if (state == MD_IDLE && in_valid && !hit) begin
            entry_valid <= 1'b0;
        end else if (state == MD_FIX) begin
            entry_valid <= 1'b1;
            entry_data  <= fix_full;
        end
    end
`else
    assign hit        = 1'b0;
    assign hit_result = '0;
`endif

    assign in_ready = (state == MD_IDLE);
    assign busy     = (state != MD_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= MD_IDLE;
            op        <= '0;
            op_a      <= '0;
            op_b      <= '0;
            acc       <= '0;
            opnd      <= '0;
            addend    <= '0;
            neg_res   <= 1'b0;
            neg_rem   <= 1'b0;
            cnt       <= '0;
            out_valid <= 1'b0;
            busC      <= '0;
        end else if (kill) begin
            state     <= MD_IDLE;
            out_valid <= 1'b0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (in_valid) begin
                        if (hit) begin
                            busC      <= hit_result;
                            out_valid <= 1'b1;
                            state     <= MD_DONE;
                        end else begin
                            op    <= funct3;
                            op_a  <= busA;
                            op_b  <= busB;
                            state <= MD_PREP;
                        end
                    end
                end
                MD_PREP: begin
                    neg_res <= (sa ^ sb) && !(is_div && b_zero);
                    neg_rem <= sa;
                    // Special cases preload acc/opnd so FIX's generic sign logic yields the result
                    if (is_div && b_zero) begin
                        acc   <= abs_a;
                        opnd  <= '1;
                        state <= MD_FIX;
                    end else if (ovf) begin
                        acc   <= '0;
                        opnd  <= abs_a;
                        state <= MD_FIX;
                    end else begin
                        acc    <= '0;
                        opnd   <= is_div ? abs_a : abs_b;
                        addend <= is_div ? abs_b : abs_a;
                        cnt    <= CW'(NSTEPS - 1);
                        state  <= MD_CALC;
                    end
                end
                MD_CALC: begin
                    acc  <= step_acc;
                    opnd <= step_opnd;
                    if (cnt == '0) begin
                        state <= MD_FIX;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                MD_FIX: begin
                    busC      <= fix_result;
                    out_valid <= 1'b1;
                    state     <= MD_DONE;
                end
                MD_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= MD_IDLE;
                    end
                end
                default: state <= MD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (XLEN=32, ITER_BITS=1) with a result scoreboard.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    localparam int LAT  = 34;
    localparam int SLAT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        kill = 1'b0;
    logic        out_ready = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] busA = '0;
    logic [31:0] busB = '0;
    logic        in_ready, out_valid, busy;
    logic [31:0] busC;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] sb_q[$];

    always #5 clk = ~clk;

    muldiv_unit #(
        .XLEN      (32),
        .ITER_BITS (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .funct3    (funct3),
        .busA      (busA),
        .busB      (busB),
        .kill      (kill),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busC      (busC),
        .busy      (busy)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] p;
        logic        ov;
        ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'b000: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'b001: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
            3'b010: begin p = {{32{a[31]}}, a} * {32'b0, b}; return p[63:32]; end
            3'b011: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'b100: return (b == 0) ? 32'hFFFF_FFFF : ov ? a : 32'($signed(a) / $signed(b));
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: return (b == 0) ? a : ov ? 32'h0 : 32'($signed(a) % $signed(b));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                          input int hold);
        int          lat;
        bit          seen;
        bit          rdy_bad;
        bit          hold_bad;
        logic [31:0] want;
        logic [31:0] held;
        @(negedge clk);
        funct3   = f3;
        busA     = a;
        busB     = b;
        in_valid = 1'b1;
        sb_q.push_back(exp);
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s accept_ready: got %b want 1", name, in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0; seen = 0; rdy_bad = 0;
        while (!seen && lat <= 200) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                seen = 1;
            end else begin
                if (in_ready !== 1'b0) rdy_bad = 1;
                @(posedge clk);
                lat++;
            end
        end
        want = sb_q.pop_front();
        n_vec++;
        if (!seen || lat != exp_lat) begin
            n_err++;
            $display("FAIL %s latency: got %0d (seen=%0d) want %0d", name, lat, seen, exp_lat);
        end
        n_vec++;
        if (rdy_bad) begin
            n_err++;
            $display("FAIL %s in_ready_busy: got 1 want 0", name);
        end
        n_vec++;
        if (busC !== want) begin
            n_err++;
            $display("FAIL %s result: got %h want %h", name, busC, want);
        end
        if (seen) begin
            if (hold > 0) begin
                held = busC;
                hold_bad = 0;
                repeat (hold) begin
                    @(negedge clk);
                    if (busC !== held || out_valid !== 1'b1 || in_ready !== 1'b0) hold_bad = 1;
                end
                n_vec++;
                if (hold_bad) begin
                    n_err++;
                    $display("FAIL %s done_hold: got busC=%h ov=%b ir=%b want busC=%h ov=1 ir=0",
                             name, busC, out_valid, in_ready, held);
                end
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            n_vec++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || busC !== want) begin
                n_err++;
                $display("FAIL %s release: got ov=%b ir=%b busC=%h want ov=0 ir=1 busC=%h",
                         name, out_valid, in_ready, busC, want);
            end
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busC !== 32'h0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: got ir=%b ov=%b busC=%h busy=%b want ir=1 ov=0 busC=0 busy=0",
                     in_ready, out_valid, busC, busy);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mul();
        run_op("mul_7_m3", MULDIV_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT, 0);
        run_op("mulh_min", MULDIV_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, LAT, 0);
        run_op("mulhu_max", MULDIV_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT, 0);
        run_op("mulhsu_m1_2", MULDIV_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, LAT, 0);
    endtask

    task automatic test_div();
        run_op("div_m7_2", MULDIV_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, LAT, 0);
        run_op("divu_100_7", MULDIV_DIVU, 32'd100, 32'd7, 32'd14, LAT, 0);
        run_op("rem_m7_2", MULDIV_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, LAT, 0);
        run_op("remu_100_7", MULDIV_REMU, 32'd100, 32'd7, 32'd2, LAT, 0);
    endtask

    task automatic test_special();
        run_op("div_by0", MULDIV_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, SLAT, 0);
        run_op("div_ovf", MULDIV_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SLAT, 0);
        run_op("rem_by0", MULDIV_REM, 32'd5, 32'd0, 32'd5, SLAT, 0);
        run_op("rem_ovf", MULDIV_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, SLAT, 0);
    endtask

    task automatic test_hold();
        run_op("hold_mul", MULDIV_MUL, 32'h1234_5678, 32'h9ABC_DEF0,
               ref_model(MULDIV_MUL, 32'h1234_5678, 32'h9ABC_DEF0), LAT, 5);
    endtask

    task automatic test_back_to_back();
        run_op("b2b_divu", MULDIV_DIVU, 32'd1000, 32'd10, 32'd100, LAT, 0);
        run_op("b2b_mul", MULDIV_MUL, 32'd6, 32'd7, 32'd42, LAT, 0);
    endtask

    task automatic test_kill();
        bit rose;
        rose = 0;
        @(negedge clk);
        funct3 = MULDIV_MUL; busA = 32'd11; busB = 32'd13; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL kill_pre_busy: got %b want 1", busy);
        end
        kill = 1'b1;
        @(posedge clk);
        #1 kill = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL kill_idle: got busy=%b ir=%b ov=%b want 0 1 0", busy, in_ready, out_valid);
        end
        repeat (40) begin
            @(negedge clk);
            if (out_valid !== 1'b0) rose = 1;
        end
        n_vec++;
        if (rose) begin
            n_err++;
            $display("FAIL kill_no_result: got out_valid=1 want 0");
        end
        @(negedge clk);
        funct3 = MULDIV_DIVU; busA = 32'd77; busB = 32'd5; in_valid = 1'b1; kill = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0; kill = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL kill_with_valid: got busy=%b ir=%b want 0 1", busy, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        funct3 = MULDIV_DIV; busA = 32'd999; busB = 32'd3; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (15) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_vec++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || busC !== 32'h0) begin
            n_err++;
            $display("FAIL reset_mid: got busy=%b ir=%b ov=%b busC=%h want 0 1 0 0",
                     busy, in_ready, out_valid, busC);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [2:0]  f3;
        logic [31:0] a, b;
        int          lat;
        for (int i = 0; i < 12; i++) begin
            f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0: a = 32'h8000_0000;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: b = 32'h0;
                1: b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            lat = LAT;
            if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
                lat = SLAT;
            run_op($sformatf("rand%0d_f%0d", i, f3), f3, a, b, ref_model(f3, a, b), lat, 0);
        end
    endtask

`ifdef MULDIV_REUSE_EN
    task automatic test_reuse();
        run_op("reuse_div", MULDIV_DIV, 32'd100, 32'd7, 32'd14, LAT, 0);
        run_op("reuse_rem_hit", MULDIV_REM, 32'd100, 32'd7, 32'd2, 0, 0);
        run_op("reuse_remu_miss", MULDIV_REMU, 32'd100, 32'd7, 32'd2, LAT, 0);
        run_op("reuse_div2", MULDIV_DIV, 32'd100, 32'd7, 32'd14, LAT, 0);
        @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        run_op("reuse_rem_killed", MULDIV_REM, 32'd100, 32'd7, 32'd2, LAT, 0);
        run_op("reuse_mulhu", MULDIV_MULHU, 32'd3, 32'd5, 32'd0, LAT, 0);
        run_op("reuse_mul_hit", MULDIV_MUL, 32'd3, 32'd5, 32'd15, 0, 0);
    endtask
`endif

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_hold();
        test_back_to_back();
        test_kill();
        test_reset_mid();
        test_random();
`ifdef MULDIV_REUSE_EN
        test_reuse();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
